// File: rtl/uart_tx_fifo_stream_if.sv
// Read-port bundle between a standard (non-FWFT) FIFO and the consumer that drains it.
// master = consumer issuing reads, slave = FIFO.
interface uart_tx_fifo_stream_if;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;

    modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/uart_tx_fifo_stream.sv
// UART transmitter draining a non-FWFT FIFO: configurable baud divisor, data width and stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_tx_fifo_stream #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_fifo_stream_if.master        fifo,
    output logic                         tx_out,
    output logic                         busy,
    output logic                         tx_done,
    output logic [15:0]                  frame_cnt
);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_fifo_stream: parameter out of legal range");
    end

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_baud;
    logic [3:0]             r_bitcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_rd_en;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif
    logic                   w_baud_end;

    assign w_baud_end      = (r_baud == BAUD_LAST);
    assign fifo.fifo_rd_en = r_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_rd_en   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            r_rd_en <= 1'b0;
            tx_done <= 1'b0;
            r_baud  <= w_baud_end ? '0 : r_baud + 16'd1;

            case (r_state)
                ST_IDLE: begin
                    tx_out   <= 1'b1;
                    r_baud   <= '0;
                    r_bitcnt <= '0;
                    if (!fifo.fifo_empty) begin
                        r_rd_en <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end

                // bit counter doubles as the FETCH phase: 0 = read in flight, 1 = data valid
                ST_FETCH: begin
                    r_baud <= '0;
                    if (r_bitcnt == 4'd0) begin
                        r_bitcnt <= 4'd1;
                    end else begin
                        r_shift  <= fifo.fifo_dout[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^fifo.fifo_dout[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
                        r_bitcnt <= '0;
                        tx_out   <= 1'b0;
                        r_state  <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_baud_end) begin
                        tx_out  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_baud_end) begin
                        if (r_bitcnt == DATA_LAST) begin
                            r_bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_out   <= r_parity;
                            r_state  <= ST_PARITY;
`else
                            tx_out   <= 1'b1;
                            r_state  <= ST_STOP;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            tx_out   <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_end) begin
                        tx_out  <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_baud_end) begin
                        if (r_bitcnt == STOP_LAST) begin
                            tx_done   <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            busy      <= 1'b0;
                            r_bitcnt  <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end

                default: begin
                    tx_out  <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_stream.sv
// Bench for uart_tx_fifo_stream: two configurations fed from FIFO models, every cycle compared
// against a frame-timeline model derived from word order, frame length and the 3-cycle fetch gap.
`timescale 1ns/1ps
module tb_uart_tx_fifo_stream;

    localparam int unsigned DIV0 = 4, DB0 = 8, SB0 = 1, ODD0 = 0;
    localparam int unsigned DIV1 = 3, DB1 = 7, SB1 = 2, ODD1 = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PBIT = 1;
`else
    localparam int unsigned PBIT = 0;
`endif
    localparam int unsigned DIVS [2] = '{DIV0, DIV1};
    localparam int unsigned DBS  [2] = '{DB0, DB1};
    localparam int unsigned SBS  [2] = '{SB0, SB1};
    localparam int unsigned ODDS [2] = '{ODD0, ODD1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx0, busy0, done0, tx1, busy1, done1;
    logic [15:0] cnt0, cnt1;
    int          cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    uart_tx_fifo_stream_if f0 ();
    uart_tx_fifo_stream_if f1 ();

    uart_tx_fifo_stream #(.CLK_DIV(DIV0), .DATA_BITS(DB0), .STOP_BITS(SB0), .PARITY_ODD(ODD0)) dut0 (
        .clk(clk), .rst(rst), .fifo(f0), .tx_out(tx0), .busy(busy0), .tx_done(done0), .frame_cnt(cnt0)
    );
    uart_tx_fifo_stream #(.CLK_DIV(DIV1), .DATA_BITS(DB1), .STOP_BITS(SB1), .PARITY_ODD(ODD1)) dut1 (
        .clk(clk), .rst(rst), .fifo(f1), .tx_out(tx1), .busy(busy1), .tx_done(done1), .frame_cnt(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Words offered to each FIFO, in order; FIFO models and reference model read them independently.
    logic [7:0] stim [2][512];
    int         stim_n [2] = '{0, 0};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         fwp0 = 0;
    int         fwp1 = 0;

    always @(posedge clk) begin
        if (f0.fifo_rd_en && q0.size() != 0) f0.fifo_dout <= q0.pop_front();
        while (fwp0 < stim_n[0]) begin q0.push_back(stim[0][fwp0]); fwp0++; end
        f0.fifo_empty <= (q0.size() == 0);
    end

    always @(posedge clk) begin
        if (f1.fifo_rd_en && q1.size() != 0) f1.fifo_dout <= q1.pop_front();
        while (fwp1 < stim_n[1]) begin q1.push_back(stim[1][fwp1]); fwp1++; end
        f1.fifo_empty <= (q1.size() == 0);
    end

    // Reference model state: current frame (start cycle, word), completed count, last done cycle.
    logic       m_v     [2] = '{1'b0, 1'b0};
    int         m_start [2] = '{0, 0};
    logic [7:0] m_w     [2];
    int         m_rp    [2] = '{0, 0};
    logic [15:0] m_cnt  [2] = '{16'd0, 16'd0};
    int         m_done  [2] = '{-1, -1};
    logic       rst_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input int k, input logic [7:0] w, input int unsigned b);
        logic par;
        if (b == 0) return 1'b0;
        if (b <= DBS[k]) return w[b-1];
        if (PBIT == 1 && b == DBS[k] + 1) begin
            par = (ODDS[k] != 0);
            for (int unsigned i = 0; i < DBS[k]; i++) par ^= w[i];
            return par;
        end
        return 1'b1;
    endfunction

    task automatic step(input int k, input logic tx, input logic bz, input logic rd,
                        input logic dn, input logic [15:0] fc, input logic empty);
        int   len;
        logic e_tx, e_busy, e_rd;
        len = int'((1 + DBS[k] + PBIT + SBS[k]) * DIVS[k]);
        if (rst_prev) begin
            m_v[k] = 1'b0; m_cnt[k] = 16'd0; m_done[k] = -1;
        end else if (m_v[k] && cyc == m_start[k] + len) begin
            m_v[k] = 1'b0; m_cnt[k] = m_cnt[k] + 16'd1; m_done[k] = cyc;
        end
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0;
        if (m_v[k]) begin
            e_rd   = (cyc == m_start[k] - 2);
            e_busy = (cyc >= m_start[k] - 2);
            if (cyc >= m_start[k]) e_tx = exp_bit(k, m_w[k], int'(cyc - m_start[k]) / DIVS[k]);
        end
        check($sformatf("tx_out%0d", k), 32'(tx), 32'(e_tx));
        check($sformatf("busy%0d", k), 32'(bz), 32'(e_busy));
        check($sformatf("rd_en%0d", k), 32'(rd), 32'(e_rd));
        check($sformatf("tx_done%0d", k), 32'(dn), 32'(cyc == m_done[k]));
        check($sformatf("frame_cnt%0d", k), 32'(fc), 32'(m_cnt[k]));
        if (!m_v[k] && !rst && empty == 1'b0 && m_rp[k] < stim_n[k]) begin
            m_v[k]     = 1'b1;
            m_start[k] = cyc + 3;
            m_w[k]     = stim[k][m_rp[k]];
            m_rp[k]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step(0, tx0, busy0, f0.fifo_rd_en, done0, cnt0, f0.fifo_empty);
        step(1, tx1, busy1, f1.fifo_rd_en, done1, cnt1, f1.fifo_empty);
        rst_prev = rst;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic add(input int k, input logic [7:0] v);
        stim[k][stim_n[k]] = v;
        stim_n[k]++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_v[0] || m_v[1] || m_rp[0] != stim_n[0] || m_rp[1] != stim_n[1]) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
        idle(4);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(20);

        add(0, 8'h55); add(1, 8'hFF);
        drain(500);

        add(0, 8'hA5); add(0, 8'h3C); add(1, 8'hFF); add(1, 8'($urandom));
        drain(500);

        add(0, 8'h07); add(1, 8'h07);
        drain(500);

        repeat (25) begin
            for (int k = 0; k < 2; k++) begin
                n = int'($urandom_range(0, 3));
                repeat (n) add(k, 8'($urandom));
            end
            idle(int'($urandom_range(0, 60)));
        end
        drain(10000);

        idle(1000);

        // clear frame_cnt, then reset in the middle of data bit 3 of dut0's first frame
        rst = 1'b1; idle(1); rst = 1'b0;
        add(0, 8'($urandom)); add(0, 8'($urandom));
        add(1, 8'($urandom)); add(1, 8'($urandom));
        n = 0;
        while (!(m_v[0] && cyc >= m_start[0] + int'(4 * DIV0)) && n < 200) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", 32'(n < 200), 32'd1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drain(1000);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_stream.md
# uart_tx_fifo_stream

Parametrised UART transmitter that drains a standard (non-FWFT) FIFO read port and serialises each word onto a single TX line. Successor to the fixed 8N1 transmitter behind the Ethernet-receive FIFO: adds configurable data width, stop bits and baud divisor, optional parity, a frame-done pulse and a frame counter. Sits in the 100 MHz UART clock domain, directly on the read side of the Ethernet-to-UART FIFO.

## Interface
Parameters:
- CLK_DIV, 868, clock cycles per UART bit (868 = 115200 baud at 100 MHz); legal range 2..65535
- DATA_BITS, 8, payload bits per frame; legal 5..8
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN)

Ports:
- clk  in  1  UART clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe, single-cycle pulse
- fifo_dout  in  8  FIFO read data, valid the cycle after rd_en is sampled by the FIFO
- tx_out  out  1  serial line, idle high
- busy  out  1  high from FIFO read issue until last stop bit ends
- tx_done  out  1  one-cycle pulse at end of each frame's last stop bit
- frame_cnt  out  16  frames completed since reset, wraps 0xFFFF->0x0000

## Operation
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0. If fifo_empty==0: register fifo_rd_en=1, busy=1, go FETCH.
- FETCH: 2 cycles. Cycle 1: fifo_rd_en=0. Cycle 2: capture fifo_dout[DATA_BITS-1:0] into shift register; go START.
- START: tx_out=0 for CLK_DIV cycles.
- DATA: DATA_BITS bits, LSB first, CLK_DIV cycles each; bits above DATA_BITS-1 of fifo_dout ignored.
- PARITY: present only with UART_TX_PARITY_EN; one bit = XOR of payload bits, inverted if PARITY_ODD=1.
- STOP: tx_out=1 for STOP_BITS*CLK_DIV cycles. On last cycle: tx_done=1, frame_cnt+1, go IDLE.
- Baud counter: counts 0..CLK_DIV-1, reloads at each bit boundary; 16-bit; bit counter 4-bit.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)*CLK_DIV cycles, P=1 with parity else 0.
- fifo_empty is not sampled outside IDLE; FIFO guarantees data once rd_en issued while non-empty.
- No read is ever issued while fifo_empty==1.

## Timing
- Reset values: tx_out=1, fifo_rd_en=0, busy=0, tx_done=0, frame_cnt=0, state IDLE, counters 0.
- Reset mid-frame: next edge tx_out=1, state IDLE; in-flight word discarded, frame_cnt not incremented, no tx_done.
- Latency: fifo_empty low in cycle t -> fifo_rd_en high cycle t+1 -> tx_out falls at cycle t+3.
- Back-to-back: after final stop cycle, IDLE re-samples fifo_empty; inter-frame idle-high gap beyond stop bits = exactly 3 cycles (IDLE + 2 FETCH).
- tx_done and frame_cnt update coincide on the same edge.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state included, frame carries parity bit per PARITY_ODD.
- Not defined: PARITY state and parity logic absent; PARITY_ODD ignored; frames are DATA_BITS-N-STOP_BITS.

## Test plan
- CLK_DIV=4, 8N1, FIFO holds 0x55 -> tx_out: 4 low, then 1,0,1,0,1,0,1,0 LSB-first each 4 cycles, 4 high; tx_done pulse; frame_cnt=1; fall at t+3.
- Two words 0xA5, 0x3C queued -> two frames, exactly 3 idle-high cycles between stop end and second start; frame_cnt=2; two rd_en pulses only.
- UART_TX_PARITY_EN, PARITY_ODD=0, word 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 11 bits.
- DATA_BITS=7, STOP_BITS=2, word 0xFF -> 7 ones after start, stop high 2*CLK_DIV cycles, bit 7 never sent.
- rst asserted during DATA bit 3 -> tx_out=1 next edge, busy=0, frame_cnt unchanged, next queued word sent as full clean frame.
- fifo_empty held high 1000 cycles -> fifo_rd_en never asserts, tx_out stays 1, busy=0.
